// File: rtl/cpu_mem_pkg.sv
// Shared types for the data-memory arbiter slice.
// FSM encoding and requester port ids.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// rr_last remembers the previous winner; a tie goes to the other port.
module rr_arbiter2
  import cpu_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = (rr_last == PORT_DMA) ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= PORT_DMA;
    end else if (take && (gnt != 2'b00)) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the LSU and the DMA loader.
// IDLE grants, ACCESS drives one strobe, RESP pulses done.
module data_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic              port_q;
  logic              we_q;
  logic              oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        arb_gnt;
  logic              take;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              acc;

  assign take = (state == IDLE) && !reset && (req0 || req1);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .take  (take),
    .gnt   (arb_gnt)
  );

  assign gnt0 = take && arb_gnt[0];
  assign gnt1 = take && arb_gnt[1];

  assign win       = arb_gnt[1];
  assign win_we    = win ? we1 : we0;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  // Out-of-range accesses still walk the FSM but never strobe memory.
  assign acc           = (state == ACCESS);
  assign mem_memRead   = acc && !we_q && !oor_q;
  assign mem_memWrite  = acc && we_q && !oor_q;
  assign mem_address   = acc ? addr_q : '0;
  assign mem_writeData = acc ? wdata_q : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      port_q  <= PORT_LSU;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            port_q  <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            oor_q   <= ({1'b0, win_addr} >= LIMIT);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q && !oor_q) begin
            if (port_q == PORT_DMA) rdata1 <= mem_readData;
            else                    rdata0 <= mem_readData;
          end
          done0 <= (port_q == PORT_LSU);
          done1 <= (port_q == PORT_DMA);
          err0  <= (port_q == PORT_LSU) && oor_q;
          err1  <= (port_q == PORT_DMA) && oor_q;
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
